// File: rtl/sc_randspawn_sched_pkg.sv
// Shared types and constants for the random spawn scheduler.
//   sched_state_e : scheduler FSM states
//   ENEMY / FUEL  : requester indices into the req/ack/grant vectors
//   LANE_W        : lane field width
//   onehot2()     : requester index -> one-hot grant vector
package sc_randsched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_e;

    localparam int ENEMY  = 0;
    localparam int FUEL   = 1;
    localparam int LANE_W = 2;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sc_randspawn_sched_if.sv
// Handshake bundle between the gameplay logic (master) and the spawn
// scheduler (slave).
//   SC_RandSched_tick_In       : one-cycle gameplay step strobe
//   SC_RandSched_random_InBUS  : random byte, [1:0] enemy lane, [5:4] fuel lane
//   SC_RandSched_req_InBUS     : spawn requests, [0] enemy, [1] fuel
//   SC_RandSched_ack_InBUS     : per-requester grant acknowledge
//   SC_RandSched_grant_OutBUS  : one-hot grant or 00
//   SC_RandSched_lane_OutBUS   : lane, valid while a grant bit is high
//   SC_RandSched_busy_Out      : scheduler not idle
interface sc_randspawn_sched_if;
    import sc_randsched_pkg::*;

    logic              SC_RandSched_tick_In;
    logic [7:0]        SC_RandSched_random_InBUS;
    logic [1:0]        SC_RandSched_req_InBUS;
    logic [1:0]        SC_RandSched_ack_InBUS;
    logic [1:0]        SC_RandSched_grant_OutBUS;
    logic [LANE_W-1:0] SC_RandSched_lane_OutBUS;
    logic              SC_RandSched_busy_Out;

    modport master (
        output SC_RandSched_tick_In,
        output SC_RandSched_random_InBUS,
        output SC_RandSched_req_InBUS,
        output SC_RandSched_ack_InBUS,
        input  SC_RandSched_grant_OutBUS,
        input  SC_RandSched_lane_OutBUS,
        input  SC_RandSched_busy_Out
    );

    modport slave (
        input  SC_RandSched_tick_In,
        input  SC_RandSched_random_InBUS,
        input  SC_RandSched_req_InBUS,
        input  SC_RandSched_ack_InBUS,
        output SC_RandSched_grant_OutBUS,
        output SC_RandSched_lane_OutBUS,
        output SC_RandSched_busy_Out
    );

endinterface

// File: rtl/sc_randspawn_sched_rr_arb.sv
// Two-way round-robin selector for the spawn scheduler.
//   clk, rst  : clock, synchronous active-high reset (reset | soft clear)
//   req       : request vector, [0] enemy, [1] fuel
//   upd       : a grant was acknowledged this cycle
//   upd_idx   : index of the acknowledged requester
//   win_valid : at least one request is present
//   win_idx   : selected requester index
// The pointer remembers the last acknowledged requester; on a tie the
// other one wins. It resets to FUEL so the first tie goes to the enemy.
module sc_randsched_rr_arb
    import sc_randsched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       win_valid,
    output logic       win_idx
);

    logic ptr_q, ptr_d;

    always_comb begin
        win_valid = |req;
        case (req)
            2'b01:   win_idx = 1'(ENEMY);
            2'b10:   win_idx = 1'(FUEL);
            2'b11:   win_idx = ~ptr_q;
            default: win_idx = 1'(ENEMY);
        endcase
        ptr_d = upd ? upd_idx : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'(FUEL);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sc_randspawn_sched.sv
// Random spawn scheduler: arbitrates enemy-car and fuel spawn requests,
// attaches a random lane to each grant and enforces a tick-counted gap
// between grants.
//   SC_RandSched_CLOCK_50     : system clock, rising edge
//   SC_RandSched_RESET_InHigh : synchronous reset, active high (wins over clear)
//   SC_RandSched_clear_InLow  : synchronous soft clear, active low
//   bus                       : sc_randspawn_sched_if slave modport
// Parameter GAP_TICKS (0..255): tick strobes between end of grant and next
// arbitration.
// Build option SC_RANDSCHED_LANE_AVOID_EN: when defined, a lane equal to the
// last granted lane is bumped to (lane+1) mod 4.
//
// state | meaning
// IDLE  | waiting for any request
// ARB   | one cycle: pick winner, capture lane
// GRANT | grant held until the winner acknowledges
// GAP   | counting GAP_TICKS ticks, requests ignored
module sc_randspawn_sched
    import sc_randsched_pkg::*;
#(
    parameter int unsigned GAP_TICKS = 8
)
(
    input  logic               SC_RandSched_CLOCK_50,
    input  logic               SC_RandSched_RESET_InHigh,
    input  logic               SC_RandSched_clear_InLow,
    sc_randspawn_sched_if.slave bus
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP_TICKS);

    sched_state_e      state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              busy_q, busy_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;

    logic              soft_rst;
    logic              ack_hit;
    logic              win_valid;
    logic              win_idx;
    logic [LANE_W-1:0] lane_raw;
    logic [LANE_W-1:0] lane_sel;
    logic              unused_rand;

    assign soft_rst    = SC_RandSched_RESET_InHigh | ~SC_RandSched_clear_InLow;
    assign ack_hit     = (state_q == ST_GRANT) && |(bus.SC_RandSched_ack_InBUS & grant_q);
    assign lane_raw    = win_idx ? bus.SC_RandSched_random_InBUS[5:4]
                                 : bus.SC_RandSched_random_InBUS[1:0];
    assign unused_rand = ^{bus.SC_RandSched_random_InBUS[7:6],
                           bus.SC_RandSched_random_InBUS[3:2]};

    sc_randsched_rr_arb u_rr_arb (
        .clk       (SC_RandSched_CLOCK_50),
        .rst       (soft_rst),
        .req       (bus.SC_RandSched_req_InBUS),
        .upd       (ack_hit),
        .upd_idx   (grant_q[FUEL]),
        .win_valid (win_valid),
        .win_idx   (win_idx)
    );

`ifdef SC_RANDSCHED_LANE_AVOID_EN
    logic [LANE_W-1:0] last_lane_q, last_lane_d;

    always_comb begin
        last_lane_d = ack_hit ? lane_q : last_lane_q;
        lane_sel    = (lane_raw == last_lane_q) ? lane_raw + 2'd1 : lane_raw;
    end

    always_ff @(posedge SC_RandSched_CLOCK_50) begin
        if (soft_rst) begin
            last_lane_q <= '0;
        end else begin
            last_lane_q <= last_lane_d;
        end
    end
`else
    assign lane_sel = lane_raw;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        lane_d    = lane_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.SC_RandSched_req_InBUS) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (win_valid) begin
                    state_d = ST_GRANT;
                    grant_d = onehot2(win_idx);
                    lane_d  = lane_sel;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A tick arriving with the ack is not counted: the counter
                // is loaded with the full gap here.
                if (ack_hit) begin
                    grant_d = 2'b00;
                    if (GAP_TICKS == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (bus.SC_RandSched_tick_In) begin
                    if (gap_cnt_q <= 8'd1) begin
                        gap_cnt_d = 8'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge SC_RandSched_CLOCK_50) begin
        if (soft_rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            lane_q    <= '0;
            busy_q    <= 1'b0;
            gap_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            lane_q    <= lane_d;
            busy_q    <= busy_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign bus.SC_RandSched_grant_OutBUS = grant_q;
    assign bus.SC_RandSched_lane_OutBUS  = lane_q;
    assign bus.SC_RandSched_busy_Out     = busy_q;

endmodule
